// File: rtl/one_of_n_route_lock_pkg.sv
// Shared definitions for the one-of-N route-lock block.
//   state_t      : IDLE (no lock, next flit is a header) / BODY (lock held)
//   DEF_LEN_LSB  : default bit position of the payload-length field in a header
//   DEF_LEN_W    : default width of the payload-length field
package one_of_n_route_lock_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } state_t;

  localparam int DEF_LEN_LSB = 22;
  localparam int DEF_LEN_W   = 8;

endpackage

// File: rtl/one_of_n_route_lock_one_of_n.sv
// Combinational one-of-N channel select.
//   sel      : channel index; values >= NUM_IN select nothing
//   data_in  : NUM_IN flits, channel i at [i*WIDTH +: WIDTH]
//   data_out : selected flit, all zeros when sel is out of range
module one_of_n #(
  parameter int WIDTH  = 64,
  parameter int NUM_IN = 5,
  parameter int SEL_W  = 3
) (
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]        data_out
);

  always_comb begin
    data_out = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) data_out = data_in[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/one_of_n_route_lock.sv
// One-of-N input router with wormhole packet lock.
// In IDLE the grant follows sel_in; a header transfer latches the grant and
// loads the remaining body-flit count from the header length field. In BODY
// the grant is fixed to the locked channel until the tail flit transfers.
// A single output register gives 1-cycle latency at full throughput.
//   clk, reset : clock, synchronous active-high reset
//   sel_in     : route-compute channel choice (used in IDLE only)
//   valid_in   : per-channel flit valid
//   data_in    : per-channel flits, channel i at [i*WIDTH +: WIDTH]
//   ready_in   : per-channel accept (only the granted channel can be high)
//   data_out   : registered output flit
//   valid_out  : data_out holds a flit
//   ready_out  : downstream accept
//   busy       : packet lock held (state BODY)
module one_of_n_route_lock
  import one_of_n_route_lock_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int NUM_IN  = 5,
  parameter int SEL_W   = 3,
  parameter int LEN_LSB = DEF_LEN_LSB,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        sel_in,
  input  logic [NUM_IN-1:0]       valid_in,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  output logic [NUM_IN-1:0]       ready_in,
  output logic [WIDTH-1:0]        data_out,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic                    busy
);

  state_t           state;
  logic [SEL_W-1:0] lock;
  logic [LEN_W-1:0] cnt;

  logic [SEL_W-1:0] grant;
  logic             can_load;
  logic             xfer;
  logic [WIDTH-1:0] flit;
  logic [LEN_W-1:0] hdr_len;

  assign grant    = (state == ST_IDLE) ? sel_in : lock;
  assign can_load = !valid_out || ready_out;

  // Out-of-range grant matches no channel, so the null select falls out of
  // the compare; reset forces ready low in the reset cycle itself.
  always_comb begin
    ready_in = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      ready_in[i] = !reset && can_load && (grant == SEL_W'(i));
    end
  end

  assign xfer = |(valid_in & ready_in);

  one_of_n #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_sel (
    .sel      (grant),
    .data_in  (data_in),
    .data_out (flit)
  );

  assign hdr_len = flit[LEN_LSB +: LEN_W];
  assign busy    = (state == ST_BODY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      lock      <= '0;
      cnt       <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
    end else begin
      // Output register: reload on transfer, drain when downstream takes it.
      if (xfer) begin
        data_out  <= flit;
        valid_out <= 1'b1;
      end else if (ready_out) begin
        valid_out <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (xfer) begin
            lock <= grant;
            cnt  <= hdr_len;
            if (hdr_len != '0) state <= ST_BODY;
          end
        end
        ST_BODY: begin
          if (xfer) begin
            cnt <= cnt - 1'b1;
            if (cnt == LEN_W'(1)) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_one_of_n_route_lock.sv
module tb_one_of_n_route_lock;
  import one_of_n_route_lock_pkg::*;

  localparam int WIDTH  = 64;
  localparam int NUM_IN = 5;
  localparam int SEL_W  = 3;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [SEL_W-1:0]        sel_in;
  logic [NUM_IN-1:0]       valid_in;
  logic [NUM_IN*WIDTH-1:0] data_in;
  logic [NUM_IN-1:0]       ready_in;
  logic [WIDTH-1:0]        data_out;
  logic                    valid_out;
  logic                    ready_out;
  logic                    busy;

  one_of_n_route_lock #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sel_in    (sel_in),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [WIDTH-1:0] sb[$];
  int out_cyc[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output side of the scoreboard: every downstream transfer pops one flit.
  always @(negedge clk) begin
    if (!reset && valid_out && ready_out) begin
      if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
      else begin
        chk("sb_data", data_out, sb.pop_front());
        out_cyc.push_back(cyc);
      end
    end
  end

  function automatic logic [WIDTH-1:0] mk_hdr(input int len);
    logic [WIDTH-1:0] h;
    h = {$urandom(), $urandom()};
    h[DEF_LEN_LSB +: DEF_LEN_W] = DEF_LEN_W'(len);
    return h;
  endfunction

  // Entered and left at posedge+1. Offers flit on channel ch (plus noise
  // valids in vmask), waits for acceptance, pushes the expected flit.
  task automatic step(input int ch, input logic [SEL_W-1:0] sel,
                      input logic [NUM_IN-1:0] vmask, input logic [WIDTH-1:0] flit,
                      input logic [NUM_IN-1:0] exp_rdy, output int waits);
    sel_in   = sel;
    valid_in = vmask | NUM_IN'(1 << ch);
    for (int i = 0; i < NUM_IN; i++) data_in[i*WIDTH +: WIDTH] = {$urandom(), $urandom()};
    data_in[ch*WIDTH +: WIDTH] = flit;
    waits = 0;
    forever begin
      @(negedge clk);
      if (ready_in[ch] || waits >= 20) break;
      waits++;
    end
    chk("ready_seen", ready_in[ch], 1);
    chk("ready_vec", ready_in, exp_rdy);
    if (ready_in[ch]) sb.push_back(flit);
    @(posedge clk); #1;
    chk("lat_valid", valid_out, 1);
    chk("lat_data", data_out, flit);
  endtask

  task automatic idle(input int n);
    valid_in = '0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic [WIDTH-1:0] f, b1;
  int w;

  initial begin
    reset = 1'b1; ready_out = 1'b1; sel_in = '0; valid_in = '1; data_in = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready_in, 0);
    @(posedge clk); #1;
    reset = 1'b0; valid_in = '0;
    chk("rst_valid", valid_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", data_out, 0);

    // Single-flit packet on channel 2
    step(2, 3'd2, 5'b11111, mk_hdr(0), 5'b00100, w);
    chk("sf_busy", busy, 0);
    idle(1);

    // Lock on channel 1 while sel_in points at 4
    step(1, 3'd1, 5'b00010, mk_hdr(3), 5'b00010, w);
    chk("lk_busy_h", busy, 1);
    step(1, 3'd4, 5'b10010, {$urandom(), $urandom()}, 5'b00010, w);
    chk("lk_busy_b1", busy, 1);
    step(1, 3'd4, 5'b10010, {$urandom(), $urandom()}, 5'b00010, w);
    chk("lk_busy_b2", busy, 1);
    step(1, 3'd4, 5'b10010, {$urandom(), $urandom()}, 5'b00010, w);
    chk("lk_busy_tail", busy, 0);
    step(4, 3'd4, 5'b00000, mk_hdr(0), 5'b10000, w);
    chk("lk_next_hdr_wait", w, 0);
    idle(2);

    // Backpressure mid-packet, length 4 on channel 0
    step(0, 3'd0, 5'b00000, mk_hdr(4), 5'b00001, w);
    b1 = {$urandom(), $urandom()};
    step(0, 3'd0, 5'b00000, b1, 5'b00001, w);
    f = {$urandom(), $urandom()};
    ready_out = 1'b0;
    valid_in = 5'b00001;
    data_in[0 +: WIDTH] = f;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready", ready_in, 0);
      chk("bp_valid", valid_out, 1);
      chk("bp_data", data_out, b1);
      chk("bp_busy", busy, 1);
      @(posedge clk); #1;
    end
    ready_out = 1'b1;
    step(0, 3'd0, 5'b00000, f, 5'b00001, w);
    chk("bp_resume_wait", w, 0);
    step(0, 3'd0, 5'b00000, {$urandom(), $urandom()}, 5'b00001, w);
    chk("bp_busy_b3", busy, 1);
    step(0, 3'd0, 5'b00000, {$urandom(), $urandom()}, 5'b00001, w);
    chk("bp_busy_tail", busy, 0);
    idle(2);

    // Reset mid-packet
    step(2, 3'd2, 5'b00000, mk_hdr(5), 5'b00100, w);
    step(2, 3'd2, 5'b00000, {$urandom(), $urandom()}, 5'b00100, w);
    step(2, 3'd2, 5'b00000, {$urandom(), $urandom()}, 5'b00100, w);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_ready", ready_in, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    chk("mr_valid", valid_out, 0);
    chk("mr_busy", busy, 0);
    step(0, 3'd0, 5'b00000, mk_hdr(0), 5'b00001, w);
    chk("mr_hdr_wait", w, 0);
    chk("mr_sf_busy", busy, 0);
    idle(2);

    // Null select
    sel_in = 3'd7; valid_in = '1;
    repeat (5) begin
      @(negedge clk);
      chk("null_ready", ready_in, 0);
      chk("null_valid", valid_out, 0);
      @(posedge clk); #1;
    end
    idle(1);

    // Back-to-back packets: lengths 2,0,1 on channels 0,3,4
    out_cyc.delete();
    step(0, 3'd0, 5'b00000, mk_hdr(2), 5'b00001, w);            chk("tp_w0", w, 0);
    step(0, 3'd3, 5'b00000, {$urandom(), $urandom()}, 5'b00001, w); chk("tp_w1", w, 0);
    step(0, 3'd3, 5'b00000, {$urandom(), $urandom()}, 5'b00001, w); chk("tp_w2", w, 0);
    step(3, 3'd3, 5'b00000, mk_hdr(0), 5'b01000, w);            chk("tp_w3", w, 0);
    step(4, 3'd4, 5'b00000, mk_hdr(1), 5'b10000, w);            chk("tp_w4", w, 0);
    step(4, 3'd0, 5'b00000, {$urandom(), $urandom()}, 5'b10000, w); chk("tp_w5", w, 0);
    idle(3);
    chk("tp_count", out_cyc.size(), 6);
    if (out_cyc.size() == 6) chk("tp_span", out_cyc[5] - out_cyc[0], 5);

    idle(3);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/one_of_n_route_lock.md
ONE_OF_N_ROUTE_LOCK -- requirements
Module: one_of_n_route_lock

Interface
REQ-001 Parameter WIDTH, default 64: flit width in bits.
REQ-002 Parameter NUM_IN, default 5: number of input channels (2..8).
REQ-003 Parameter SEL_W, default 3: select width; 2^SEL_W >= NUM_IN.
REQ-004 Parameter LEN_LSB, default 22, and LEN_W, default 8: position and width of the payload-length field in a header flit.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 sel_in  input  SEL_W  route-compute choice of input channel; sampled only in IDLE.
REQ-008 valid_in  input  NUM_IN  per-channel flit valid.
REQ-009 data_in  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 ready_in  output  NUM_IN  per-channel accept; flit i transfers when valid_in[i] && ready_in[i].
REQ-011 data_out  output  WIDTH  registered output flit.
REQ-012 valid_out  output  1  data_out holds a flit.
REQ-013 ready_out  input  1  downstream accept; transfer when valid_out && ready_out.
REQ-014 busy  output  1  high while a packet lock is held (state BODY).

Function
REQ-015 The block SHALL implement states IDLE and BODY.
REQ-016 ready_in[i] SHALL be high only for i == current grant and only when the output register can load (!valid_out || ready_out); all other bits SHALL be 0.
REQ-017 In IDLE, grant SHALL equal sel_in; sel_in >= NUM_IN SHALL mean null: ready_in all 0, no transfer, state unchanged.
REQ-018 A header transfer in IDLE SHALL latch sel_in as the locked grant and load the remaining-flit counter with data[LEN_LSB +: LEN_W].
REQ-019 Header with length 0 SHALL leave the state in IDLE (single-flit packet); nonzero length SHALL move to BODY.
REQ-020 In BODY, sel_in SHALL be ignored; grant SHALL be the locked channel; each transfer SHALL decrement the counter; the transfer that takes the counter from 1 to 0 SHALL return to IDLE.
REQ-021 The IDLE-to-BODY and BODY-to-IDLE transitions SHALL occur on the edge of the causing transfer; a new header from any channel SHALL be acceptable in the cycle immediately after the tail transfer.
REQ-022 Latency input-transfer to valid_out SHALL be exactly 1 cycle; data_out SHALL be the transferred flit unmodified.
REQ-023 With valid_out && ready_out and a simultaneous input transfer, the register SHALL reload with no bubble (full throughput, one flit per cycle).
REQ-024 With valid_out && !ready_out, data_out and valid_out SHALL hold and ready_in SHALL be all 0.
REQ-025 With no input transfer and ready_out high, valid_out SHALL drop to 0 next cycle.
REQ-026 valid_in on non-granted channels SHALL have no effect on any state.
REQ-027 busy SHALL equal (state == BODY).

Reset
REQ-028 While reset is high on a clock edge: state SHALL become IDLE, counter 0, locked grant 0, valid_out 0, data_out all zeros; ready_in SHALL be 0 in the reset cycle.
REQ-029 Reset mid-packet SHALL discard the lock and any held flit; the next flit accepted SHALL be treated as a header.

Structure
REQ-030 State encoding (IDLE/BODY) and the default LEN_LSB/LEN_W values SHALL live in the shared dynamic-node package/define file.
REQ-031 The combinational channel select SHALL be a sub-module one_of_n (WIDTH, NUM_IN parameters, out-of-range select yields zero).

Verification
REQ-032 Single-flit: sel_in=2, valid_in[2]=1, header length 0, ready_out=1 -> ready_in=5'b00100, flit on data_out next cycle, busy stays 0.
REQ-033 Lock: sel_in=1, header length 3, then sel_in toggled to 4 with valid_in[4]=1 -> only channel 1 granted for 4 flits total, busy high 3 cycles, channel 4 header accepted the cycle after the tail.
REQ-034 Null select: sel_in=7 with all valid_in high for 5 cycles -> ready_in=0, valid_out=0 throughout.
REQ-035 Backpressure: ready_out=0 for 3 cycles mid-packet (length 4) -> data_out stable, counter unchanged, ready_in=0; resumes with no lost or duplicated flit.
REQ-036 Reset mid-packet: header length 5, reset after 2 body flits -> valid_out=0, busy=0 next cycle; next flit with length 0 on sel_in=0 completes as single-flit packet.
REQ-037 Throughput: back-to-back packets lengths 2,0,1 on channels 0,3,4 with ready_out=1 -> 6 flits out on 6 consecutive cycles.
